// File: rtl/time_event_scheduler_pkg.sv
// time_package: shared types for the global-time scheduler.
//   TIME_FORMAT   - absolute emulated time (unsigned)
//   TIME_MAX      - all-ones time, used as the "no candidate yet" seed of the min scan
//   sched_state_t - scheduler FSM states
package time_package;

    localparam int TIME_W = 32;

    typedef logic [TIME_W-1:0] TIME_FORMAT;

    localparam TIME_FORMAT TIME_MAX = '1;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/time_event_scheduler_if.sv
// Request/grant bundle between the N emulated blocks and the scheduler.
//   req_valid[i] - requester i is presenting req_time[i]
//   req_time[i]  - absolute time of requester i's next event
//   req_ready[i] - one-cycle grant pulse that consumes request i
// master: requester side, slave: scheduler side.
interface time_event_scheduler_if #(
    parameter int N = 4
);
    import time_package::*;

    logic [N-1:0] req_valid;
    TIME_FORMAT   req_time [N];
    logic [N-1:0] req_ready;

    modport master (
        output req_valid,
        output req_time,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_time,
        output req_ready
    );

endinterface

// File: rtl/time_event_scheduler_min_scan.sv
// time_min_scan: sequential argmin over N request times, one index per cycle.
//   start    - seed a new scan (idx=0, min=TIME_MAX) at the next edge
//   active   - examine index idx this cycle
//   mask     - only masked entries take part
//   req_time - candidate times
//   idx      - index being examined this cycle
//   min_d    - value the running minimum takes at the next edge; on the
//              done cycle this is the final minimum of the scan
//   done     - active and examining the last index
module time_min_scan
    import time_package::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic [N-1:0]     mask,
    input  TIME_FORMAT       req_time [N],
    output logic [IDX_W-1:0] idx,
    output TIME_FORMAT       min_d,
    output logic             done
);

    logic [IDX_W-1:0] idx_q, idx_d;
    TIME_FORMAT       min_q;

    assign done = active && (idx_q == IDX_W'(N - 1));
    assign idx  = idx_q;

    always_comb begin
        idx_d = idx_q;
        min_d = min_q;
        if (start) begin
            idx_d = '0;
            min_d = TIME_MAX;
        end else if (active) begin
            // Strict compare: an all-TIME_MAX round keeps the seed, which is still correct.
            if (mask[idx_q] && (req_time[idx_q] < min_q)) begin
                min_d = req_time[idx_q];
            end
            // Park at 0 after the last index so idx never leaves the array range.
            idx_d = done ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            min_q <= TIME_MAX;
        end else begin
            idx_q <= idx_d;
            min_q <= min_d;
        end
    end

endmodule

// File: rtl/time_event_scheduler.sv
// time_event_scheduler: global-time sequencer.
// Waits until every enabled requester has posted, scans for the earliest time
// (one index per cycle), then commits: advances time_curr (never backwards) and
// pulses req_ready for every enabled requester due at that time.
//   clk, rst (async, active-low)
//   run / step      - free-run, or one commit per step pulse while paused
//   en_mask         - requesters taking part in scheduling
//   req_if          - request/grant bundle (slave side)
//   time_curr       - committed global time
//   time_next       - minimum found by the last scan
//   adv_pulse       - one-cycle pulse on every commit
//   step_count      - commit counter, wraps
//   causality_err   - sticky: a request earlier than time_curr was seen
//   err_src         - index of the first offending requester
module time_event_scheduler
    import time_package::*;
#(
    parameter  int N     = 4,
    parameter  int CNT_W = 32,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic [N-1:0]            en_mask,
    time_event_scheduler_if.slave   req_if,
    output TIME_FORMAT              time_curr,
    output TIME_FORMAT              time_next,
    output logic                    adv_pulse,
    output logic [CNT_W-1:0]        step_count,
    output logic                    causality_err,
    output logic [IDX_W-1:0]        err_src
);

    sched_state_t     state_q, state_d;
    logic [N-1:0]     mask_q, mask_d;
    logic             step_pending_q, step_pending_d;
    TIME_FORMAT       time_curr_q, time_curr_d;
    TIME_FORMAT       time_next_q, time_next_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic             causality_err_q, causality_err_d;
    logic [IDX_W-1:0] err_src_q, err_src_d;
    logic [N-1:0]     req_ready_q, req_ready_d;
    logic             adv_pulse_q, adv_pulse_d;

    logic             go;
    logic             scan_start;
    logic             scan_active;
    logic             scan_done;
    logic [IDX_W-1:0] scan_idx;
    TIME_FORMAT       scan_min_d;
    logic [N-1:0]     grant_hit;

    assign go = (run || step_pending_q) && (en_mask != '0) &&
                ((req_if.req_valid & en_mask) == en_mask);
    assign scan_start  = (state_q == S_WAIT) && go;
    assign scan_active = (state_q == S_SCAN);

    time_min_scan #(.N(N)) u_min_scan (
        .clk      (clk),
        .rst      (rst),
        .start    (scan_start),
        .active   (scan_active),
        .mask     (mask_q),
        .req_time (req_if.req_time),
        .idx      (scan_idx),
        .min_d    (scan_min_d),
        .done     (scan_done)
    );

    // Grants are decided against the final minimum on the last scan cycle so
    // the registered pulse lines up with the commit cycle; ties all win.
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant_hit[gi] = mask_q[gi] && (req_if.req_time[gi] == scan_min_d);
    end

    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        time_curr_d     = time_curr_q;
        time_next_d     = time_next_q;
        step_count_d    = step_count_q;
        causality_err_d = causality_err_q;
        err_src_d       = err_src_q;
        req_ready_d     = '0;
        adv_pulse_d     = 1'b0;
        // A step landing on the commit edge is kept for the following round.
        step_pending_d  = (scan_done ? 1'b0 : step_pending_q) | (step & ~run);

        case (state_q)
            S_WAIT: begin
                if (go) begin
                    state_d = S_SCAN;
                    mask_d  = en_mask;
                end
            end
            S_SCAN: begin
                if (mask_q[scan_idx] && (req_if.req_time[scan_idx] < time_curr_q) &&
                    !causality_err_q) begin
                    causality_err_d = 1'b1;
                    err_src_d       = scan_idx;
                end
                if (scan_done) begin
                    state_d      = S_COMMIT;
                    time_next_d  = scan_min_d;
                    time_curr_d  = (scan_min_d > time_curr_q) ? scan_min_d : time_curr_q;
                    step_count_d = step_count_q + 1'b1;
                    req_ready_d  = grant_hit;
                    adv_pulse_d  = 1'b1;
                end
            end
            S_COMMIT: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_WAIT;
            mask_q          <= '0;
            step_pending_q  <= 1'b0;
            time_curr_q     <= '0;
            time_next_q     <= '0;
            step_count_q    <= '0;
            causality_err_q <= 1'b0;
            err_src_q       <= '0;
            req_ready_q     <= '0;
            adv_pulse_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            step_pending_q  <= step_pending_d;
            time_curr_q     <= time_curr_d;
            time_next_q     <= time_next_d;
            step_count_q    <= step_count_d;
            causality_err_q <= causality_err_d;
            err_src_q       <= err_src_d;
            req_ready_q     <= req_ready_d;
            adv_pulse_q     <= adv_pulse_d;
        end
    end

    assign req_if.req_ready = req_ready_q;
    assign time_curr        = time_curr_q;
    assign time_next        = time_next_q;
    assign adv_pulse        = adv_pulse_q;
    assign step_count       = step_count_q;
    assign causality_err    = causality_err_q;
    assign err_src          = err_src_q;

endmodule

// File: tb/tb_time_event_scheduler.sv
// Directed bench for time_event_scheduler (N=4): barrier, min select, ties,
// causality, pause/step, empty mask and asynchronous reset mid-scan.
module tb_time_event_scheduler;
    import time_package::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic [N-1:0] en_mask = '0;
    TIME_FORMAT   time_curr, time_next;
    logic         adv_pulse;
    logic [31:0]  step_count;
    logic         causality_err;
    logic [1:0]   err_src;

    int n_cmp = 0;
    int n_bad = 0;

    time_event_scheduler_if #(.N(N)) bus ();

    time_event_scheduler #(.N(N), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .step          (step),
        .en_mask       (en_mask),
        .req_if        (bus),
        .time_curr     (time_curr),
        .time_next     (time_next),
        .adv_pulse     (adv_pulse),
        .step_count    (step_count),
        .causality_err (causality_err),
        .err_src       (err_src)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post4(input TIME_FORMAT t0, input TIME_FORMAT t1,
                         input TIME_FORMAT t2, input TIME_FORMAT t3);
        bus.req_time[0] = t0;
        bus.req_time[1] = t1;
        bus.req_time[2] = t2;
        bus.req_time[3] = t3;
    endtask

    // Runs exactly max_cyc cycles; records the first grant (cycle and vector),
    // counts adv pulses, and drops valid for the granted requesters.
    task automatic wait_grant(input int max_cyc, output int cyc,
                              output logic [N-1:0] rdy, output int advs);
        cyc  = -1;
        rdy  = '0;
        advs = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (adv_pulse === 1'b1) advs++;
            if (cyc < 0 && bus.req_ready != '0) begin
                cyc = i;
                rdy = bus.req_ready;
                bus.req_valid = bus.req_valid & ~bus.req_ready;
                $display("grant: cycle=%0d ready=%b time_curr=%0d step_count=%0d",
                         cyc, rdy, time_curr, step_count);
            end
        end
    endtask

    task automatic test_reset;
        en_mask = 4'b1111;
        run = 1'b1;
        bus.req_valid = '0;
        post4(0, 0, 0, 0);
        tick(2);
        n_cmp++; if (time_curr !== 0) begin n_bad++; $display("FAIL rst_time_curr: got %0d want 0", time_curr); end
        n_cmp++; if (time_next !== 0) begin n_bad++; $display("FAIL rst_time_next: got %0d want 0", time_next); end
        n_cmp++; if (step_count !== 0) begin n_bad++; $display("FAIL rst_step_count: got %0d want 0", step_count); end
        n_cmp++; if (adv_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_adv: got %b want 0", adv_pulse); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (causality_err !== 1'b0) begin n_bad++; $display("FAIL rst_cerr: got %b want 0", causality_err); end
        n_cmp++; if (err_src !== 2'd0) begin n_bad++; $display("FAIL rst_err_src: got %0d want 0", err_src); end
        rst = 1'b1;
        tick(3);
        n_cmp++; if (step_count !== 0) begin n_bad++; $display("FAIL idle_step_count: got %0d want 0", step_count); end
        $display("reset: released, outputs checked");
    endtask

    task automatic test_barrier;
        int cyc, advs;
        logic [N-1:0] rdy;
        post4(20, 25, 30, 0);
        bus.req_valid = 4'b0111;
        wait_grant(20, cyc, rdy, advs);
        n_cmp++; if (cyc !== -1) begin n_bad++; $display("FAIL barrier_hold: grant at cycle %0d want none", cyc); end
        n_cmp++; if (advs !== 0) begin n_bad++; $display("FAIL barrier_adv: got %0d want 0", advs); end
        bus.req_time[3] = 5;
        bus.req_valid[3] = 1'b1;
        wait_grant(6, cyc, rdy, advs);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL barrier_latency: got %0d want 5", cyc); end
        n_cmp++; if (rdy !== 4'b1000) begin n_bad++; $display("FAIL barrier_ready: got %b want 1000", rdy); end
        n_cmp++; if (time_curr !== 5) begin n_bad++; $display("FAIL barrier_time: got %0d want 5", time_curr); end
        n_cmp++; if (step_count !== 1) begin n_bad++; $display("FAIL barrier_count: got %0d want 1", step_count); end
    endtask

    task automatic test_min_select;
        int cyc, advs;
        logic [N-1:0] rdy;
        post4(30, 10, 20, 40);
        bus.req_valid = 4'b1111;
        wait_grant(7, cyc, rdy, advs);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL min_latency: got %0d want 5", cyc); end
        n_cmp++; if (rdy !== 4'b0010) begin n_bad++; $display("FAIL min_ready: got %b want 0010", rdy); end
        n_cmp++; if (time_curr !== 10) begin n_bad++; $display("FAIL min_time_curr: got %0d want 10", time_curr); end
        n_cmp++; if (time_next !== 10) begin n_bad++; $display("FAIL min_time_next: got %0d want 10", time_next); end
        n_cmp++; if (step_count !== 2) begin n_bad++; $display("FAIL min_count: got %0d want 2", step_count); end
        n_cmp++; if (advs !== 1) begin n_bad++; $display("FAIL min_adv: got %0d want 1", advs); end
    endtask

    task automatic test_tie;
        int cyc, advs;
        logic [N-1:0] rdy;
        post4(15, 15, 50, 15);
        bus.req_valid = 4'b1111;
        wait_grant(8, cyc, rdy, advs);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL tie_latency: got %0d want 5", cyc); end
        n_cmp++; if (rdy !== 4'b1011) begin n_bad++; $display("FAIL tie_ready: got %b want 1011", rdy); end
        n_cmp++; if (time_curr !== 15) begin n_bad++; $display("FAIL tie_time: got %0d want 15", time_curr); end
        n_cmp++; if (advs !== 1) begin n_bad++; $display("FAIL tie_adv: got %0d want 1", advs); end
        n_cmp++; if (step_count !== 3) begin n_bad++; $display("FAIL tie_count: got %0d want 3", step_count); end
    endtask

    task automatic test_causality;
        int cyc, advs;
        logic [N-1:0] rdy;
        post4(100, 200, 200, 200);
        bus.req_valid = 4'b1111;
        wait_grant(7, cyc, rdy, advs);
        n_cmp++; if (rdy !== 4'b0001) begin n_bad++; $display("FAIL caus_setup_ready: got %b want 0001", rdy); end
        n_cmp++; if (time_curr !== 100) begin n_bad++; $display("FAIL caus_setup_time: got %0d want 100", time_curr); end
        n_cmp++; if (causality_err !== 1'b0) begin n_bad++; $display("FAIL caus_clean: got %b want 0", causality_err); end
        bus.req_time[0] = 150;
        bus.req_time[2] = 90;
        bus.req_valid = 4'b1111;
        wait_grant(7, cyc, rdy, advs);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL caus_latency: got %0d want 5", cyc); end
        n_cmp++; if (rdy !== 4'b0100) begin n_bad++; $display("FAIL caus_ready: got %b want 0100", rdy); end
        n_cmp++; if (time_curr !== 100) begin n_bad++; $display("FAIL caus_clamp: got %0d want 100", time_curr); end
        n_cmp++; if (time_next !== 90) begin n_bad++; $display("FAIL caus_time_next: got %0d want 90", time_next); end
        n_cmp++; if (causality_err !== 1'b1) begin n_bad++; $display("FAIL caus_flag: got %b want 1", causality_err); end
        n_cmp++; if (err_src !== 2'd2) begin n_bad++; $display("FAIL caus_src: got %0d want 2", err_src); end
        n_cmp++; if (step_count !== 5) begin n_bad++; $display("FAIL caus_count: got %0d want 5", step_count); end
    endtask

    task automatic test_pause_step;
        int cyc, advs;
        logic [N-1:0] rdy;
        logic [N-1:0] exp_rdy [3];
        TIME_FORMAT   exp_t   [3];
        exp_rdy = '{4'b0001, 4'b1010, 4'b0100};
        exp_t   = '{150, 200, 300};
        run = 1'b0;
        bus.req_time[2] = 300;
        bus.req_valid = 4'b1111;
        wait_grant(10, cyc, rdy, advs);
        n_cmp++; if (advs !== 0) begin n_bad++; $display("FAIL pause_hold: got %0d commits want 0", advs); end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            wait_grant(8, cyc, rdy, advs);
            n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL step%0d_latency: got %0d want 5", s, cyc); end
            n_cmp++; if (rdy !== exp_rdy[s]) begin n_bad++; $display("FAIL step%0d_ready: got %b want %b", s, rdy, exp_rdy[s]); end
            n_cmp++; if (time_curr !== exp_t[s]) begin n_bad++; $display("FAIL step%0d_time: got %0d want %0d", s, time_curr, exp_t[s]); end
            n_cmp++; if (advs !== 1) begin n_bad++; $display("FAIL step%0d_adv: got %0d want 1", s, advs); end
            // Granted requesters re-post 300 later.
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) bus.req_time[i] = bus.req_time[i] + 300;
            end
            bus.req_valid = 4'b1111;
        end
        wait_grant(10, cyc, rdy, advs);
        n_cmp++; if (advs !== 0) begin n_bad++; $display("FAIL step_done_hold: got %0d commits want 0", advs); end
        n_cmp++; if (step_count !== 8) begin n_bad++; $display("FAIL step_count: got %0d want 8", step_count); end
        en_mask = 4'b0000;
        run = 1'b1;
        wait_grant(10, cyc, rdy, advs);
        n_cmp++; if (advs !== 0) begin n_bad++; $display("FAIL empty_mask_adv: got %0d want 0", advs); end
        n_cmp++; if (step_count !== 8) begin n_bad++; $display("FAIL empty_mask_count: got %0d want 8", step_count); end
    endtask

    task automatic test_async_reset;
        int cyc, advs;
        logic [N-1:0] rdy;
        en_mask = 4'b1111;
        // Pending requests are {450,500,600,500}, all valid.
        tick(2);
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (time_curr !== 0) begin n_bad++; $display("FAIL arst_time_curr: got %0d want 0", time_curr); end
        n_cmp++; if (time_next !== 0) begin n_bad++; $display("FAIL arst_time_next: got %0d want 0", time_next); end
        n_cmp++; if (step_count !== 0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", step_count); end
        n_cmp++; if (causality_err !== 1'b0) begin n_bad++; $display("FAIL arst_cerr: got %b want 0", causality_err); end
        n_cmp++; if (err_src !== 2'd0) begin n_bad++; $display("FAIL arst_err_src: got %0d want 0", err_src); end
        tick(5);
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL arst_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (adv_pulse !== 1'b0) begin n_bad++; $display("FAIL arst_adv: got %b want 0", adv_pulse); end
        rst = 1'b1;
        wait_grant(7, cyc, rdy, advs);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL resume_latency: got %0d want 5", cyc); end
        n_cmp++; if (rdy !== 4'b0001) begin n_bad++; $display("FAIL resume_ready: got %b want 0001", rdy); end
        n_cmp++; if (time_curr !== 450) begin n_bad++; $display("FAIL resume_time: got %0d want 450", time_curr); end
        n_cmp++; if (step_count !== 1) begin n_bad++; $display("FAIL resume_count: got %0d want 1", step_count); end
    endtask

    initial begin
        bus.req_valid = '0;
        post4(0, 0, 0, 0);
        test_reset();
        test_barrier();
        test_min_select();
        test_tie();
        test_causality();
        test_pause_step();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
